pkt_dispatch_ctrl: RTL and testbench
====================================

PKT_DISPATCH_CTRL -- requirements
Module: pkt_dispatch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles waited for a stage done before abandoning that stage.
REQ-002 SHALL have parameter ID_W, default 16: node ID width.
REQ-003 clk  in  1  single clock; all flops rise on posedge clk.
REQ-004 nrst  in  1  reset; asynchronous, active-low.
REQ-005 newpkt  in  1  one-cycle strobe, packet header valid.
REQ-006 fPktType  in  3  packet type, sampled with newpkt.
REQ-007 myNodeID, destinationID  in  ID_W each  own ID, packet destination, sampled with newpkt.
REQ-008 done_MNI, done_KCH, done_QTU, done_reward  in  1 each  downstream completion pulses.
REQ-009 en_MNI, en_KCH, en_QTU, en_reward  out  1 each  one-cycle stage-start pulses.
REQ-010 iAmDestination  out  1  held high while the active packet has destinationID == myNodeID.
REQ-011 busy  out  1  high while a packet is in any stage.
REQ-012 pkt_drop  out  1  one-cycle pulse when a packet is discarded.
REQ-013 timeout_err  out  1  one-cycle pulse when a stage times out.

Function
REQ-014 SHALL implement states IDLE, S_MNI, S_KCH, S_QTU, S_RWD; stages run strictly in that order, unrequired stages skipped.
REQ-015 Stage map SHALL be: 000 MNI+RWD; 001 MNI+KCH; 010 KCH+RWD; 011 QTU+RWD; 100 MNI+RWD; 101/110 QTU, plus RWD only if iAmDestination; 111 none.
REQ-016 Type 111 SHALL not start processing and SHALL pulse pkt_drop the cycle after newpkt.
REQ-017 newpkt in IDLE at cycle N SHALL latch the header and pulse the first stage's enable at cycle N+1, busy high from N+1.
REQ-018 Each enable SHALL pulse exactly once, on the first cycle of its state; the matching done is honored from the following cycle onward, ignored on the enable cycle, and non-matching dones are ignored.
REQ-019 done in a stage SHALL move to the next required stage (enable pulsed next cycle), or to IDLE/pending dispatch if none remains.
REQ-020 A 5-bit-or-wider wait counter SHALL clear on stage entry; reaching TIMEOUT cycles without done SHALL pulse timeout_err and advance as if done.
REQ-021 newpkt while busy SHALL be stored in a one-entry pending slot; newpkt while busy with the slot full SHALL be dropped with pkt_drop.
REQ-022 Final-stage done with the slot valid SHALL dispatch the pending packet next cycle, keeping busy high with no IDLE cycle.
REQ-023 Final-stage done, slot full, and newpkt in the same cycle SHALL promote the pending packet, store the new one, and pulse no pkt_drop.
REQ-024 iAmDestination SHALL be computed from the latched IDs and SHALL be 0 in IDLE.

Reset
REQ-025 nrst low SHALL asynchronously force IDLE, clear the pending slot, wait counter, and drop_cnt, and drive every output to 0, including mid-stage.
REQ-026 The first newpkt after nrst rises SHALL be handled as in REQ-017.

Configuration
REQ-027 With PKT_DROP_CNT_EN defined, SHALL add output drop_cnt (8 bits) counting pkt_drop pulses, saturating at 255, reset 0.
REQ-028 Without PKT_DROP_CNT_EN, drop_cnt port and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 The shared package pkt_defs SHALL hold the packet-type constants (PKT_HB=000 to PKT_SOS=110, PKT_INV_TYPE=111), the state encoding, and the TIMEOUT default.
REQ-030 The one-entry pending slot SHALL be a sub-module pkt_pending_buf (push/pop/valid, type+IDs payload).

Verification
REQ-031 Type 000, IDs equal, done_MNI at +2, done_reward at +2 -> en_MNI at N+1, en_reward the cycle after done_MNI, busy drops after done_reward.
REQ-032 Type 101, myNodeID=0x0005, dest=0x0007 -> only en_QTU; no en_reward; iAmDestination=0.
REQ-033 Type 001 with no done_MNI -> timeout_err after 16 cycles, then en_KCH next cycle.
REQ-034 Three newpkt while busy (slot empty at start) -> second stored, third gives pkt_drop=1; with the macro, drop_cnt=1.
REQ-035 Final done, slot full, and newpkt in the same cycle -> no pkt_drop; both packets processed back-to-back, busy continuous.
REQ-036 nrst low mid-S_QTU -> all outputs 0 immediately; new type-011 packet after release -> en_QTU at N+1.

Source files
------------

// File: rtl/pkt_defs.sv
// Shared definitions for the packet dispatch controller.
// Holds packet-type codes, the dispatch FSM state encoding, the default stage
// timeout, and helpers that map a packet type to its stage list and walk it.
// Optional build macro used by the top: PKT_DROP_CNT_EN.
package pkt_defs;

  localparam int unsigned TIMEOUT_DEF = 16;

  // Packet type codes carried on fPktType
  localparam logic [2:0] PKT_HB       = 3'b000;
  localparam logic [2:0] PKT_DATA     = 3'b001;
  localparam logic [2:0] PKT_ACK      = 3'b010;
  localparam logic [2:0] PKT_ROUTE    = 3'b011;
  localparam logic [2:0] PKT_SYNC     = 3'b100;
  localparam logic [2:0] PKT_ALERT    = 3'b101;
  localparam logic [2:0] PKT_SOS      = 3'b110;
  localparam logic [2:0] PKT_INV_TYPE = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_MNI = 3'd1,
    S_KCH = 3'd2,
    S_QTU = 3'd3,
    S_RWD = 3'd4
  } pkt_state_e;

  // Stage mask bit order: {MNI, KCH, QTU, RWD}
  function automatic logic [3:0] stage_map(input logic [2:0] ptype,
                                           input logic       dst_match);
    logic [3:0] m;
    case (ptype)
      PKT_HB, PKT_SYNC:  m = 4'b1001;
      PKT_DATA:          m = 4'b1100;
      PKT_ACK:           m = 4'b0101;
      PKT_ROUTE:         m = 4'b0011;
      PKT_ALERT, PKT_SOS: m = {3'b001, dst_match};
      default:           m = 4'b0000;
    endcase
    return m;
  endfunction

  // Next required stage strictly after cur (IDLE = before the first stage)
  function automatic pkt_state_e next_stage(input pkt_state_e cur,
                                            input logic [3:0] m);
    pkt_state_e nxt;
    nxt = IDLE;
    case (cur)
      IDLE: begin
        if (m[3])      nxt = S_MNI;
        else if (m[2]) nxt = S_KCH;
        else if (m[1]) nxt = S_QTU;
        else if (m[0]) nxt = S_RWD;
      end
      S_MNI: begin
        if (m[2])      nxt = S_KCH;
        else if (m[1]) nxt = S_QTU;
        else if (m[0]) nxt = S_RWD;
      end
      S_KCH: begin
        if (m[1])      nxt = S_QTU;
        else if (m[0]) nxt = S_RWD;
      end
      S_QTU: begin
        if (m[0])      nxt = S_RWD;
      end
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pkt_pending_buf.sv
// One-entry holding slot for a packet header that arrives while busy.
// Ports: clk, nrst; push stores in_* (wins over pop, so push+pop replaces the
// entry); pop empties the slot; valid/out_* present the held header.
module pkt_pending_buf #(
  parameter int unsigned ID_W = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            push,
  input  logic            pop,
  input  logic [2:0]      in_type,
  input  logic [ID_W-1:0] in_my_id,
  input  logic [ID_W-1:0] in_dst_id,
  output logic            valid,
  output logic [2:0]      out_type,
  output logic [ID_W-1:0] out_my_id,
  output logic [ID_W-1:0] out_dst_id
);

  // Slot storage
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid      <= 1'b0;
      out_type   <= 3'b000;
      out_my_id  <= '0;
      out_dst_id <= '0;
    end else if (push) begin
      valid      <= 1'b1;
      out_type   <= in_type;
      out_my_id  <= in_my_id;
      out_dst_id <= in_dst_id;
    end else if (pop) begin
      valid      <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_dispatch_ctrl.sv
// Packet dispatch controller: runs each packet through its required subset of
// the MNI -> KCH -> QTU -> RWD stages, with per-stage timeout and a one-entry
// pending slot for headers that arrive while busy.
// Ports: clk, nrst (async active-low); newpkt/fPktType/myNodeID/destinationID
// header strobe; done_* stage completions; en_* stage-start pulses; busy;
// iAmDestination; pkt_drop and timeout_err pulses.
// Build macro PKT_DROP_CNT_EN adds drop_cnt, a saturating count of pkt_drop.
module pkt_dispatch_ctrl
  import pkt_defs::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned ID_W    = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            newpkt,
  input  logic [2:0]      fPktType,
  input  logic [ID_W-1:0] myNodeID,
  input  logic [ID_W-1:0] destinationID,
  input  logic            done_MNI,
  input  logic            done_KCH,
  input  logic            done_QTU,
  input  logic            done_reward,
  output logic            en_MNI,
  output logic            en_KCH,
  output logic            en_QTU,
  output logic            en_reward,
  output logic            iAmDestination,
  output logic            busy,
  output logic            pkt_drop,
  output logic            timeout_err
`ifdef PKT_DROP_CNT_EN
  ,
  output logic [7:0]      drop_cnt
`endif
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  pkt_state_e      state_q, state_n;
  logic [2:0]      type_q, type_n;
  logic [ID_W-1:0] my_q, my_n, dst_q, dst_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic            first_q, first_n;

  logic            pend_valid, push, pop;
  logic [2:0]      pend_type;
  logic [ID_W-1:0] pend_my, pend_dst;

  logic            ld;
  logic [2:0]      ld_type;
  logic [ID_W-1:0] ld_my, ld_dst;
  logic            new_ok, new_taken, done_sel, adv;
  pkt_state_e      nxt;
  logic            drop_n, tmo_n, busy_n, iam_n;
  logic [3:0]      en_n;

  pkt_pending_buf #(.ID_W(ID_W)) u_pend (
    .clk        (clk),
    .nrst       (nrst),
    .push       (push),
    .pop        (pop),
    .in_type    (fPktType),
    .in_my_id   (myNodeID),
    .in_dst_id  (destinationID),
    .valid      (pend_valid),
    .out_type   (pend_type),
    .out_my_id  (pend_my),
    .out_dst_id (pend_dst)
  );

  // State and latched header
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      type_q  <= 3'b000;
      my_q    <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_n;
      type_q  <= type_n;
      my_q    <= my_n;
      dst_q   <= dst_n;
      cnt_q   <= cnt_n;
      first_q <= first_n;
    end
  end

  // Next-state, slot control and next output values
  always_comb begin
    state_n   = state_q;
    type_n    = type_q;
    my_n      = my_q;
    dst_n     = dst_q;
    cnt_n     = cnt_q;
    first_n   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ld        = 1'b0;
    ld_type   = fPktType;
    ld_my     = myNodeID;
    ld_dst    = destinationID;
    new_taken = 1'b0;
    done_sel  = 1'b0;
    adv       = 1'b0;
    tmo_n     = 1'b0;
    nxt       = IDLE;

    new_ok = newpkt && (fPktType != PKT_INV_TYPE);
    drop_n = newpkt && (fPktType == PKT_INV_TYPE);

    case (state_q)
      S_MNI:   done_sel = done_MNI;
      S_KCH:   done_sel = done_KCH;
      S_QTU:   done_sel = done_QTU;
      S_RWD:   done_sel = done_reward;
      default: done_sel = 1'b0;
    endcase

    // Done is ignored on the enable cycle; reaching TIMEOUT forces the advance
    if (state_q != IDLE) begin
      adv   = (!first_q && done_sel) || (cnt_q == CNT_W'(TIMEOUT));
      tmo_n = !adv && (cnt_q == CNT_W'(TIMEOUT - 1));
      cnt_n = cnt_q + CNT_W'(1);
    end

    if (state_q == IDLE) begin
      if (new_ok) begin
        ld        = 1'b1;
        new_taken = 1'b1;
      end
    end else if (adv) begin
      nxt = next_stage(state_q, stage_map(type_q, my_q == dst_q));
      if (nxt != IDLE) begin
        state_n = nxt;
        cnt_n   = '0;
        first_n = 1'b1;
      end else if (pend_valid) begin
        pop     = 1'b1;
        ld      = 1'b1;
        ld_type = pend_type;
        ld_my   = pend_my;
        ld_dst  = pend_dst;
      end else if (new_ok) begin
        ld        = 1'b1;
        new_taken = 1'b1;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end

    // Start a packet from its first required stage
    if (ld) begin
      type_n  = ld_type;
      my_n    = ld_my;
      dst_n   = ld_dst;
      state_n = next_stage(IDLE, stage_map(ld_type, ld_my == ld_dst));
      cnt_n   = '0;
      first_n = 1'b1;
    end

    // A header arriving while busy goes to the slot if it is (or is becoming) free
    if (new_ok && !new_taken) begin
      if (!pend_valid || pop) push = 1'b1;
      else                    drop_n = 1'b1;
    end

    en_n   = {first_n && (state_n == S_MNI), first_n && (state_n == S_KCH),
              first_n && (state_n == S_QTU), first_n && (state_n == S_RWD)};
    busy_n = (state_n != IDLE);
    iam_n  = busy_n && (my_n == dst_n);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_MNI         <= 1'b0;
      en_KCH         <= 1'b0;
      en_QTU         <= 1'b0;
      en_reward      <= 1'b0;
      busy           <= 1'b0;
      iAmDestination <= 1'b0;
      pkt_drop       <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      {en_MNI, en_KCH, en_QTU, en_reward} <= en_n;
      busy           <= busy_n;
      iAmDestination <= iam_n;
      pkt_drop       <= drop_n;
      timeout_err    <= tmo_n;
    end
  end

`ifdef PKT_DROP_CNT_EN
  // Saturating drop counter, stepped on the same edge that raises pkt_drop
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                         drop_cnt <= 8'd0;
    else if (drop_n && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  // Drop counter not built
`endif

endmodule

// File: tb/tb_pkt_dispatch_ctrl.sv
// Directed bench for pkt_dispatch_ctrl: a table of {inputs, expected outputs}
// rows run back to back, plus hand sequences for timeout and async reset.
// Observed vector order: {en_MNI, en_KCH, en_QTU, en_reward, busy, iAmDestination, pkt_drop, timeout_err}.
module tb_pkt_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        newpkt;
  logic [2:0]  fPktType;
  logic [15:0] myNodeID, destinationID;
  logic        done_MNI, done_KCH, done_QTU, done_reward;
  logic        en_MNI, en_KCH, en_QTU, en_reward;
  logic        iAmDestination, busy, pkt_drop, timeout_err;
`ifdef PKT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  pkt_dispatch_ctrl #(.TIMEOUT(16), .ID_W(16)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .newpkt         (newpkt),
    .fPktType       (fPktType),
    .myNodeID       (myNodeID),
    .destinationID  (destinationID),
    .done_MNI       (done_MNI),
    .done_KCH       (done_KCH),
    .done_QTU       (done_QTU),
    .done_reward    (done_reward),
    .en_MNI         (en_MNI),
    .en_KCH         (en_KCH),
    .en_QTU         (en_QTU),
    .en_reward      (en_reward),
    .iAmDestination (iAmDestination),
    .busy           (busy),
    .pkt_drop       (pkt_drop),
    .timeout_err    (timeout_err)
`ifdef PKT_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  logic [7:0] obs;
  assign obs = {en_MNI, en_KCH, en_QTU, en_reward, busy, iAmDestination, pkt_drop, timeout_err};

  typedef struct {
    logic        np;
    logic [2:0]  ty;
    logic [15:0] my;
    logic [15:0] dst;
    logic [3:0]  dn;   // {MNI, KCH, QTU, reward}
    logic [7:0]  ex;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;
  int   exp_drops = 0;

  function automatic void add(input logic np, input logic [2:0] ty, input logic [15:0] my,
                              input logic [15:0] dst, input logic [3:0] dn, input logic [7:0] ex);
    vec_t v;
    v.np = np; v.ty = ty; v.my = my; v.dst = dst; v.dn = dn; v.ex = ex;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, got, want);
    end
  endtask

  task automatic chk_cnt(input string nm);
`ifdef PKT_DROP_CNT_EN
    chk(nm, drop_cnt, 8'(exp_drops));
`else
    nm = nm;
`endif
  endtask

  // Drive one cycle of inputs, advance past the edge, check registered outputs
  task automatic run(input string nm, input logic np, input logic [2:0] ty, input logic [15:0] my,
                     input logic [15:0] dst, input logic [3:0] dn, input logic [7:0] ex);
    newpkt = np; fPktType = ty; myNodeID = my; destinationID = dst;
    {done_MNI, done_KCH, done_QTU, done_reward} = dn;
    @(posedge clk); #1;
    newpkt = 1'b0;
    {done_MNI, done_KCH, done_QTU, done_reward} = 4'b0000;
    if (ex[1]) exp_drops++;
    chk(nm, obs, ex);
    chk_cnt({nm, "_cnt"});
  endtask

  initial begin
    nrst = 1'b0; newpkt = 1'b0; fPktType = 3'b000; myNodeID = 16'h0; destinationID = 16'h0;
    {done_MNI, done_KCH, done_QTU, done_reward} = 4'b0000;
    #12;
    chk("reset", obs, 8'b0000_0000);
    chk_cnt("reset_cnt");
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    // Type 000, IDs equal: MNI then reward
    add(1, 3'b000, 16'h1, 16'h1, 4'b0000, 8'b1000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b1000, 8'b0001_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b0000_0000);
    // Type 101, not destination: QTU only; dones on enable cycle and wrong dones ignored
    add(1, 3'b101, 16'h5, 16'h7, 4'b0000, 8'b0010_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0011, 8'b0000_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b0000_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0010, 8'b0000_0000);
    // Type 110, destination: QTU then reward
    add(1, 3'b110, 16'h9, 16'h9, 4'b0000, 8'b0010_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0010, 8'b0001_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b0000_0000);
    // Invalid type dropped from idle
    add(1, 3'b111, 16'h2, 16'h2, 4'b0000, 8'b0000_0010);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_0000);
    // Three headers while busy: second held, third dropped, held one follows
    add(1, 3'b001, 16'h1, 16'h2, 4'b0000, 8'b1000_1000);
    add(1, 3'b010, 16'h3, 16'h3, 4'b0000, 8'b0000_1000);
    add(1, 3'b000, 16'h4, 16'h4, 4'b0000, 8'b0000_1010);
    add(0, 3'b000, 16'h0, 16'h0, 4'b1000, 8'b0100_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0100, 8'b0100_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0100, 8'b0001_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b0000_0000);
    // Final done + full slot + new header together: promote, store, no drop
    add(1, 3'b011, 16'h1, 16'h2, 4'b0000, 8'b0010_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1000);
    add(1, 3'b100, 16'h4, 16'h4, 4'b0000, 8'b0000_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0010, 8'b0001_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1000);
    add(1, 3'b001, 16'h6, 16'h6, 4'b0001, 8'b1000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b1000, 8'b0001_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b1000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b1000, 8'b0100_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0100, 8'b0000_0000);
    // Final done with empty slot + new header: starts directly, busy stays high
    add(1, 3'b011, 16'h1, 16'h1, 4'b0000, 8'b0010_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0010, 8'b0001_1100);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    add(1, 3'b100, 16'h2, 16'h3, 4'b0001, 8'b1000_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b1000, 8'b0001_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1000);
    add(0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b0000_0000);

    foreach (vecs[i])
      run($sformatf("row%0d", i), vecs[i].np, vecs[i].ty, vecs[i].my, vecs[i].dst,
          vecs[i].dn, vecs[i].ex);

    // Timeout: no done_MNI for type 001 -> timeout_err at +17, en_KCH at +18
    run("tmo_start", 1, 3'b001, 16'h1, 16'h2, 4'b0000, 8'b1000_1000);
    for (int k = 2; k <= 18; k++) begin
      logic [7:0] want;
      want = (k == 17) ? 8'b0000_1001 : (k == 18) ? 8'b0100_1000 : 8'b0000_1000;
      run($sformatf("tmo_k%0d", k), 0, 3'b000, 16'h0, 16'h0, 4'b0000, want);
    end
    run("tmo_kch_en", 0, 3'b000, 16'h0, 16'h0, 4'b0100, 8'b0000_1000);
    run("tmo_kch_done", 0, 3'b000, 16'h0, 16'h0, 4'b0100, 8'b0000_0000);

    // Async reset in the middle of S_QTU, then a fresh type-011 packet
    run("rst_pre_en", 1, 3'b011, 16'h1, 16'h2, 4'b0000, 8'b0010_1000);
    run("rst_pre_busy", 0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1000);
    #2 nrst = 1'b0;
    #1;
    exp_drops = 0;
    chk("rst_async", obs, 8'b0000_0000);
    chk_cnt("rst_async_cnt");
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;
    run("rst_post_en", 1, 3'b011, 16'h3, 16'h3, 4'b0000, 8'b0010_1100);
    run("rst_post_w", 0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    run("rst_post_q", 0, 3'b000, 16'h0, 16'h0, 4'b0010, 8'b0001_1100);
    run("rst_post_w2", 0, 3'b000, 16'h0, 16'h0, 4'b0000, 8'b0000_1100);
    run("rst_post_r", 0, 3'b000, 16'h0, 16'h0, 4'b0001, 8'b0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
